data_sync_tx_arbiter: RTL and testbench
=======================================

Name: data_sync_tx_arbiter

Overview:
Source-clock-domain controller that shares one multi-bit CDC data crossing between NUM_REQ requesters. It arbitrates round-robin and drives the shared unsync_bus and bus_en level into the destination-domain data synchronizer. It runs a 4-phase handshake against a destination acknowledge level, synchronizing that level internally. Only one transfer is in flight at a time; data is held stable for the whole transfer.

Parameters:
bus_width, 8, data width per transfer
NUM_REQ, 4, number of requesters (2..16)
NUM_STAGES, 2, synchronizer depth for dst_ack (>=2)
TIMEOUT_CYCLES, 255, per-phase ack wait limit; used only with ARB_TIMEOUT_EN

Ports:
CLK  in  1  source-domain clock
RST  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester request level; held until its grant pulse
req_data  in  NUM_REQ*bus_width  requester i data at bits [i*bus_width +: bus_width]
grant  out  NUM_REQ  one-hot, 1-cycle pulse; req_data of winner captured on this edge
done  out  NUM_REQ  one-hot, 1-cycle pulse; transfer fully acknowledged
unsync_bus  out  bus_width  registered data to destination synchronizer
bus_en  out  1  registered transfer-valid level to destination synchronizer
dst_ack  in  1  asynchronous ack level from destination domain
busy  out  1  high whenever state != IDLE
src_id  out  clog2(NUM_REQ)  index of current/last granted requester
timeout_err  out  1  1-cycle error pulse (see Optional Feature)

Behaviour:
- Reset (async, RST=0): all outputs 0; state IDLE; ack sync chain 0; round-robin pointer 0 (requester 0 highest priority).
- ack_s = dst_ack after NUM_STAGES flops; FSM uses ack_s only.
- IDLE: if req != 0, winner = first set bit searching from pointer upward with wrap. On that edge: unsync_bus <= winner data, src_id <= winner, grant[winner] pulses, pointer <= winner+1 mod NUM_REQ, state -> SETUP. If req == 0, outputs hold; unsync_bus keeps its last value.
- SETUP: 1 cycle, data precedes enable. Next edge: bus_en <= 1, state -> WAIT_ACK.
- WAIT_ACK: when ack_s == 1, bus_en <= 0, state -> WAIT_REL.
- WAIT_REL: when ack_s == 0, done[src_id] pulses, state -> IDLE.
- Minimum cycle: grant at edge E, bus_en rises at E+1. With ack_s already 0, the next grant is possible on the edge after done.
- unsync_bus is constant from grant until the next grant; it never changes while bus_en = 1 or ack_s = 1.
- req changes during a transfer are ignored; sampling happens only in IDLE.
- Requester i re-requesting immediately loses to any other pending requester, giving strict round-robin fairness.
- ack_s == 1 while in IDLE or SETUP is a stale ack: hold in SETUP, bus_en stays 0, until ack_s == 0.
- Reset mid-transfer: immediate return to reset values. No done or timeout_err is issued for the aborted transfer.
- NUM_REQ == 1: pointer is constant 0.

Optional Feature:
ARB_TIMEOUT_EN defined:
- A counter clears on entry to WAIT_ACK and to WAIT_REL, and increments each cycle in those states.
- Reaching TIMEOUT_CYCLES in WAIT_ACK: bus_en <= 0, go to WAIT_REL, counter cleared.
- Reaching TIMEOUT_CYCLES in WAIT_REL: timeout_err pulses 1 cycle, no done, state -> IDLE.
- Counter width is clog2(TIMEOUT_CYCLES+1).
ARB_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; timeout_err is tied 0.

Test Plan:
- Single transfer: req=4'b0010, data1=8'hA5; ack returned 3 cycles after bus_en rise -> grant=4'b0010 one cycle. Then unsync_bus=8'hA5 with bus_en high one cycle later. bus_en falls NUM_STAGES+1 cycles after dst_ack rises. done=4'b0010 after dst_ack falls and is synchronized.
- Round-robin: req=4'b1111 held, data i=8'h10+i, auto-ack model -> grants in order 0,1,2,3,0. Each unsync_bus value matches the winner; no grant while busy=1.
- Fairness wrap: pointer=3 after granting 2, req=4'b0101 -> grant order 0 then 2.
- Data stability: change req_data every cycle during a transfer -> unsync_bus constant from grant to next grant; bus_en never high in the same cycle unsync_bus changes.
- Reset mid-transfer: assert RST low in WAIT_ACK -> bus_en, unsync_bus, busy, grant, done all 0 asynchronously. After release with req=4'b1000, grant=4'b1000.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): dst_ack stuck 0 -> bus_en falls 8 cycles after rising. timeout_err pulses 8 cycles later, no done, busy=0. The next request is granted normally.

Source files
------------

// File: rtl/data_sync_tx_arbiter_if.sv
// Requester/destination-side bundle of the shared CDC data crossing arbiter.
// master = arbiter side, slave = requesters plus destination ack.
interface data_sync_tx_arbiter_if #(
    parameter int bus_width = 8,
    parameter int NUM_REQ   = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*bus_width-1:0] req_data;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic [bus_width-1:0]         unsync_bus;
    logic                         bus_en;
    logic                         dst_ack;
    logic                         busy;
    logic [ID_W-1:0]              src_id;
    logic                         timeout_err;

    modport master (
        input  req, req_data, dst_ack,
        output grant, done, unsync_bus, bus_en, busy, src_id, timeout_err
    );

    modport slave (
        output req, req_data, dst_ack,
        input  grant, done, unsync_bus, bus_en, busy, src_id, timeout_err
    );
endinterface

// File: rtl/data_sync_tx_arbiter.sv
// Round-robin source-side arbiter for one shared 4-phase CDC data crossing; bus_en rises 1 cycle after grant.
// Requests wait while a transfer is in flight; define ARB_TIMEOUT_EN for per-phase ack timeouts.
module data_sync_tx_arbiter #(
    parameter int bus_width      = 8,
    parameter int NUM_REQ        = 4,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    data_sync_tx_arbiter_if.master bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;

    state_t                 state;
    logic [NUM_STAGES-1:0]  ack_sync;
    logic                   ack_s;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        win_idx;
    logic [ID_W-1:0]        ptr_nxt;
    logic                   win_vld;
    logic [bus_width-1:0]   win_data;
    logic [NUM_REQ-1:0]     grant_r;
    logic [NUM_REQ-1:0]     done_r;
    logic [bus_width-1:0]   bus_r;
    logic                   bus_en_r;
    logic                   busy_r;
    logic [ID_W-1:0]        src_id_r;
    logic                   rel_ok;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) ack_sync <= '0;
        else      ack_sync <= {ack_sync[NUM_STAGES-2:0], bus.dst_ack};
    end
    assign ack_s = ack_sync[NUM_STAGES-1];

    // First pending request at or above the pointer, wrapping around.
    always_comb begin : pick
        logic [ID_W:0] j;
        j       = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = {1'b0, ptr} + (ID_W+1)'(k);
            if (j >= (ID_W+1)'(NUM_REQ)) j = j - (ID_W+1)'(NUM_REQ);
            if (!win_vld && bus.req[j[ID_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = j[ID_W-1:0];
            end
        end
    end

    assign ptr_nxt  = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    assign win_data = bus.req_data[int'(win_idx)*bus_width +: bus_width];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
    logic [CNT_W-1:0] cnt;
    logic             ack_missed;
    logic             tmo_err_r;
    logic             tmo_hit;
    assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYCLES-1));
    // After a missed ack the release phase never completes normally; it runs to its own timeout.
    assign rel_ok  = !ack_s && !ack_missed;
    assign bus.timeout_err = tmo_err_r;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg  = (TIMEOUT_CYCLES != 0);
    assign rel_ok          = !ack_s;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_r  <= '0;
            done_r   <= '0;
            bus_r    <= '0;
            bus_en_r <= 1'b0;
            busy_r   <= 1'b0;
            src_id_r <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt        <= '0;
            ack_missed <= 1'b0;
            tmo_err_r  <= 1'b0;
`endif
        end else begin
            grant_r <= '0;
            done_r  <= '0;
`ifdef ARB_TIMEOUT_EN
            tmo_err_r <= 1'b0;
`endif
            case (state)
                IDLE: if (win_vld) begin
                    bus_r    <= win_data;
                    src_id_r <= win_idx;
                    grant_r  <= NUM_REQ'(1) << win_idx;
                    ptr      <= ptr_nxt;
                    busy_r   <= 1'b1;
                    state    <= SETUP;
                end
                // A stale ack from the previous transfer holds off the enable.
                SETUP: if (!ack_s) begin
                    bus_en_r <= 1'b1;
                    state    <= WAIT_ACK;
`ifdef ARB_TIMEOUT_EN
                    cnt      <= '0;
`endif
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        bus_en_r <= 1'b0;
                        state    <= WAIT_REL;
`ifdef ARB_TIMEOUT_EN
                        cnt        <= '0;
                        ack_missed <= 1'b0;
                    end else if (tmo_hit) begin
                        bus_en_r   <= 1'b0;
                        state      <= WAIT_REL;
                        cnt        <= '0;
                        ack_missed <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                WAIT_REL: begin
                    if (rel_ok) begin
                        done_r <= NUM_REQ'(1) << src_id_r;
                        busy_r <= 1'b0;
                        state  <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        tmo_err_r <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_r;
    assign bus.done       = done_r;
    assign bus.unsync_bus = bus_r;
    assign bus.bus_en     = bus_en_r;
    assign bus.busy       = busy_r;
    assign bus.src_id     = src_id_r;
endmodule

// File: tb/tb_data_sync_tx_arbiter.sv
// Bench for data_sync_tx_arbiter: directed handshake timing, a round-robin vector table, and random traffic vs a transaction model.
module tb_data_sync_tx_arbiter;
    localparam int BW = 8;
    localparam int NR = 4;
    localparam int NS = 2;
    localparam int TO = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    data_sync_tx_arbiter_if #(.bus_width(BW), .NUM_REQ(NR)) ifc();

    data_sync_tx_arbiter #(
        .bus_width(BW), .NUM_REQ(NR), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc)
    );

    always #5 CLK = ~CLK;

    int vec_cnt = 0;
    int mis_cnt = 0;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] gnt;
        logic [BW-1:0] bus;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_grant();
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ifc.grant != '0) break;
        end
    endtask

    // Destination responder: ack shortly after bus_en, release once bus_en drops; scrambles req_data meanwhile.
    task automatic run_ack(input string nm, input logic [NR-1:0] exp_done);
        logic [BW-1:0]    held;
        logic [NR*BW-1:0] keep;
        logic [NR-1:0]    dv;
        bit               stable;
        bit               extra;
        int               w;
        held = ifc.unsync_bus; keep = ifc.req_data;
        dv = '0; stable = 1'b1; extra = 1'b0; w = 0;
        for (int n = 0; n < 100; n++) begin
            ifc.req_data = $urandom();
            tick();
            if (ifc.grant != '0) extra = 1'b1;
            if (ifc.unsync_bus !== held) stable = 1'b0;
            if (ifc.done != '0) begin dv = ifc.done; break; end
            if (ifc.bus_en && !ifc.dst_ack) begin
                if (w >= 2) ifc.dst_ack = 1'b1; else w++;
            end else if (!ifc.bus_en && ifc.dst_ack) begin
                ifc.dst_ack = 1'b0;
            end
        end
        ifc.req_data = keep;
        chk({nm, "_done"}, 32'(dv), 32'(exp_done));
        chk({nm, "_no_grant_while_busy"}, 32'(extra), 32'd0);
        chk({nm, "_bus_stable"}, 32'(stable), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0]    req_v;
        logic [NR*BW-1:0] dat_v;
        logic [BW-1:0]    held_m;
        int               ptr_m, cur_m, w, rsp_cnt, stall, n;
        bit               in_fl, rel_seen, dn_seen;
        logic [NR-1:0]    exp_g;

        ifc.req = '0; ifc.req_data = '0; ifc.dst_ack = 1'b0;

        // Reset state
        #12;
        chk("rst_grant", 32'(ifc.grant), 0);
        chk("rst_done", 32'(ifc.done), 0);
        chk("rst_bus_en", 32'(ifc.bus_en), 0);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_unsync_bus", 32'(ifc.unsync_bus), 0);
        chk("rst_src_id", 32'(ifc.src_id), 0);
        chk("rst_timeout_err", 32'(ifc.timeout_err), 0);
        #5 RST = 1'b1;
        tick();

        // Single transfer with exact handshake timing
        ifc.req_data = {8'h13, 8'h12, 8'hA5, 8'h10};
        ifc.req = 4'b0010;
        tick();
        chk("single_grant", 32'(ifc.grant), 32'h2);
        chk("single_bus", 32'(ifc.unsync_bus), 32'hA5);
        chk("single_src_id", 32'(ifc.src_id), 32'd1);
        chk("single_busy", 32'(ifc.busy), 32'd1);
        chk("single_setup_en", 32'(ifc.bus_en), 32'd0);
        ifc.req = '0;
        tick();
        chk("single_en_rise", 32'(ifc.bus_en), 32'd1);
        chk("single_grant_pulse", 32'(ifc.grant), 32'd0);
        tick(); tick(); tick();
        ifc.dst_ack = 1'b1;
        for (int i = 0; i < NS; i++) tick();
        chk("single_en_held", 32'(ifc.bus_en), 32'd1);
        tick();
        chk("single_en_fall", 32'(ifc.bus_en), 32'd0);
        ifc.dst_ack = 1'b0;
        for (int i = 0; i < NS; i++) tick();
        chk("single_done_early", 32'(ifc.done), 32'd0);
        tick();
        chk("single_done", 32'(ifc.done), 32'h2);
        chk("single_idle", 32'(ifc.busy), 32'd0);
        tick();
        chk("single_done_pulse", 32'(ifc.done), 32'd0);

        // Reset in WAIT_ACK
        ifc.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        ifc.req = 4'b0001;
        tick();
        ifc.req = '0;
        tick();
        chk("mid_en_before_rst", 32'(ifc.bus_en), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_bus_en", 32'(ifc.bus_en), 0);
        chk("mid_rst_bus", 32'(ifc.unsync_bus), 0);
        chk("mid_rst_busy", 32'(ifc.busy), 0);
        chk("mid_rst_grant", 32'(ifc.grant), 0);
        chk("mid_rst_done", 32'(ifc.done), 0);
        tick(); tick();
        RST = 1'b1;
        ifc.req = 4'b1000;
        tick();
        chk("mid_post_grant", 32'(ifc.grant), 32'h8);
        ifc.req = '0;
        run_ack("mid_post", 4'b1000);

        // Round-robin / fairness table (pointer 0 at entry)
        tbl[0] = '{4'b1111, 4'b0001, 8'h10};
        tbl[1] = '{4'b1111, 4'b0010, 8'h11};
        tbl[2] = '{4'b1111, 4'b0100, 8'h12};
        tbl[3] = '{4'b1111, 4'b1000, 8'h13};
        tbl[4] = '{4'b1111, 4'b0001, 8'h10};
        tbl[5] = '{4'b0100, 4'b0100, 8'h12};
        tbl[6] = '{4'b0101, 4'b0001, 8'h10};
        tbl[7] = '{4'b0101, 4'b0100, 8'h12};
        tbl[8] = '{4'b1010, 4'b1000, 8'h13};
        tbl[9] = '{4'b1010, 4'b0010, 8'h11};
        for (int i = 0; i < 10; i++) begin
            ifc.req = tbl[i].req;
            wait_grant();
            chk($sformatf("tbl%0d_grant", i), 32'(ifc.grant), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_bus", i), 32'(ifc.unsync_bus), 32'(tbl[i].bus));
            run_ack($sformatf("tbl%0d", i), tbl[i].gnt);
        end
        ifc.req = '0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Stuck-low ack: both phases time out, error pulse instead of done
        ifc.req = 4'b0001;
        tick();
        chk("tmo_grant", 32'(ifc.grant), 32'h1);
        ifc.req = '0;
        tick();
        chk("tmo_en_rise", 32'(ifc.bus_en), 32'd1);
        n = 0;
        while (ifc.bus_en && n < 40) begin tick(); n++; end
        chk("tmo_en_fall_cycles", 32'(n), 32'(TO));
        n = 0; dn_seen = 1'b0;
        while (!ifc.timeout_err && n < 40) begin
            tick(); n++;
            if (ifc.done != '0) dn_seen = 1'b1;
        end
        chk("tmo_err_cycles", 32'(n), 32'(TO));
        chk("tmo_no_done", 32'(dn_seen), 32'd0);
        chk("tmo_idle", 32'(ifc.busy), 32'd0);
        tick();
        chk("tmo_err_pulse", 32'(ifc.timeout_err), 32'd0);
        ifc.req = 4'b0010;
        wait_grant();
        chk("tmo_next_grant", 32'(ifc.grant), 32'h2);
        ifc.req = '0;
        run_ack("tmo_next", 4'b0010);
`endif

        // Random traffic against a transaction-level model
        ptr_m = 2; in_fl = 1'b0; cur_m = 0; held_m = '0;
        req_v = '0; dat_v = '0; rsp_cnt = 0; stall = 0; rel_seen = 1'b0;
        ifc.req = '0; ifc.req_data = '0; ifc.dst_ack = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            exp_g = '0; w = 0;
            if (!in_fl && req_v != '0) begin
                for (int k = 0; k < NR; k++) begin
                    if (req_v[(ptr_m + k) % NR]) begin w = (ptr_m + k) % NR; break; end
                end
                exp_g = NR'(1) << w;
            end
            chk("rnd_grant", 32'(ifc.grant), 32'(exp_g));
            if (exp_g != '0) begin
                held_m = dat_v[w*BW +: BW];
                chk("rnd_bus_capture", 32'(ifc.unsync_bus), 32'(held_m));
                chk("rnd_src_id", 32'(ifc.src_id), 32'(w));
                in_fl = 1'b1; cur_m = w; rel_seen = 1'b0;
                ptr_m = (w + 1) % NR;
                req_v[w] = 1'b0;
            end else if (in_fl) begin
                chk("rnd_bus_hold", 32'(ifc.unsync_bus), 32'(held_m));
            end
            if (ifc.done != '0) begin
                chk("rnd_done", 32'(ifc.done), (in_fl && rel_seen) ? 32'(NR'(1) << cur_m) : 32'd0);
                in_fl = 1'b0;
            end
            chk("rnd_busy", 32'(ifc.busy), 32'(in_fl));
            stall = in_fl ? stall + 1 : 0;
            if (stall > 100) begin
                chk("rnd_stall_cycles", 32'(stall), 32'd100);
                break;
            end
            if (ifc.bus_en && !ifc.dst_ack) begin
                if (rsp_cnt == 0) begin ifc.dst_ack = 1'b1; rsp_cnt = $urandom_range(0, 3); end
                else rsp_cnt--;
            end else if (!ifc.bus_en && ifc.dst_ack) begin
                if (rsp_cnt == 0) begin ifc.dst_ack = 1'b0; rel_seen = 1'b1; rsp_cnt = $urandom_range(0, 3); end
                else rsp_cnt--;
            end
            for (int i = 0; i < NR; i++)
                if (!req_v[i] && $urandom_range(0, 2) == 0) req_v[i] = 1'b1;
            dat_v = $urandom();
            ifc.req = req_v;
            ifc.req_data = dat_v;
        end
        ifc.req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end
endmodule
